noc_out_port_mux: RTL and testbench
===================================

// Module: noc_out_port_mux
// PURPOSE
//  Parametrised router output-port stage: selects one of NUM_PORTS input channels by grant, locks the
//  selection for a whole wormhole packet (head..tail), buffers accepted flits in a 2-entry output queue,
//  and drives a valid/ready link. One instance per router output; port index map 0=N,1=E,2=S,3=W,4=PE.
// PARAMETERS
//  NUM_PORTS  5   number of input channels (>=2)
//  FLIT_W     32  flit width in bits (>=4); bits [FLIT_W-1:FLIT_W-2] = flit type
//  GRANT_W    3   grant index width, >= clog2(NUM_PORTS)
//  CNT_W      16  width of accepted-flit counter
// PORTS
//  clk         in   1                    clock, all state on rising edge
//  rst_n       in   1                    asynchronous active-low reset
//  grant_valid in   1                    grant field is meaningful this cycle
//  grant       in   GRANT_W              binary index of granted input
//  in_flit     in   NUM_PORTS*FLIT_W     packed flits, port i at [i*FLIT_W +: FLIT_W]
//  in_valid    in   NUM_PORTS            per-port flit valid
//  in_ready    out  NUM_PORTS            per-port accept (combinational)
//  out_flit    out  FLIT_W               head entry of output queue
//  out_valid   out  1                    out_flit valid
//  out_ready   in   1                    downstream accepts out_flit
//  locked      out  1                    packet lock held
//  lock_port   out  GRANT_W              port holding lock (valid when locked)
//  grant_err   out  1                    1-cycle pulse: grant_valid with grant>=NUM_PORTS while unlocked
//  proto_err   out  1                    1-cycle pulse: flit type illegal for current lock state
//  flit_cnt    out  CNT_W                flits accepted since reset, wraps
// BEHAVIOUR
//  Clock/reset: one clock clk; rst_n asynchronous, active-low. All outputs/state clear on reset:
//   out_valid=0, out_flit=0, queue empty, locked=0, lock_port=0, grant_err=0, proto_err=0, flit_cnt=0.
//   Reset mid-packet drops lock and queued flits; no flush handshake.
//  Flit type: 00 HEAD, 01 BODY, 10 TAIL, 11 SINGLE (head+tail).
//  FSM IDLE/LOCKED:
//   IDLE: sel=grant, sel_ok=grant_valid && grant<NUM_PORTS. Accept of HEAD -> LOCKED, lock_port=sel.
//         SINGLE stays IDLE. BODY/TAIL accepted in IDLE: forwarded, proto_err pulse, stay IDLE.
//   LOCKED: sel=lock_port, sel_ok=1, grant/grant_valid ignored. Accept of TAIL -> IDLE.
//         HEAD or SINGLE in LOCKED: forwarded, proto_err pulse, stay LOCKED (lock_port unchanged).
//  Accept: in_ready[i] = sel_ok && (i==sel) && !q_full; all other in_ready=0. Transfer = in_valid[sel]&&in_ready[sel].
//  Queue: 2-entry FIFO. Push on transfer, pop on out_valid&&out_ready. out_valid=!q_empty; out_flit = head entry
//   (registered, 0 when empty). Latency: flit accepted in cycle t appears on out_flit at t+1.
//   Full: in_ready=0 even if a pop occurs same cycle (no bypass). Empty: no pop; out_flit held 0.
//   Push+pop same cycle: occupancy unchanged, order preserved. Sustains 1 flit/cycle while out_ready=1.
//  Error flags registered: asserted cycle after the offending event, for exactly one cycle per event.
//  flit_cnt increments by 1 per transfer, wraps 2^CNT_W-1 -> 0. No X is ever driven on any output.
// TESTING
//  1. Reset: rst_n=0 async mid-cycle -> out_valid=0, out_flit=0, locked=0, flit_cnt=0 immediately.
//  2. IDLE grant=4, PE sends SINGLE 0xC0000005, out_ready=1 -> in_ready=5'b10000, out_flit=0xC0000005 next cycle, locked stays 0.
//  3. grant=1, E sends HEAD,BODY,TAIL; grant changes to 2 after HEAD -> E keeps in_ready, S in_ready=0, locked=0 after TAIL, flit_cnt=3.
//  4. out_ready=0, 3 flits offered -> 2 accepted then in_ready=0; out_ready=1 -> flits emerge in order, no loss/dup.
//  5. grant_valid=1, grant=6 in IDLE -> all in_ready=0, grant_err one-cycle pulse; BODY in IDLE -> proto_err pulse, flit forwarded.
//  6. Reset asserted while LOCKED with 2 queued -> queue empty, locked=0; after release, new grant accepted normally.

Source files
------------

// File: rtl/noc_out_port_mux.sv
// Router output-port stage: grant select, wormhole lock,
// 2-entry output queue and valid/ready link to downstream.
module noc_out_port_mux #(
  parameter int NUM_PORTS = 5,
  parameter int FLIT_W    = 32,
  parameter int GRANT_W   = 3,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        grant_valid,
  input  logic [GRANT_W-1:0]          grant,
  input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic [FLIT_W-1:0]           out_flit,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        locked,
  output logic [GRANT_W-1:0]          lock_port,
  output logic                        grant_err,
  output logic                        proto_err,
  output logic [CNT_W-1:0]            flit_cnt
);

  localparam logic [1:0] T_HEAD = 2'b00;
  localparam logic [1:0] T_BODY = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_SNGL = 2'b11;
  localparam logic [GRANT_W:0] NP = (GRANT_W+1)'(NUM_PORTS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state;
  logic [GRANT_W-1:0] lport;
  logic [FLIT_W-1:0]  q0;
  logic [FLIT_W-1:0]  q1;
  logic [1:0]         q_cnt;

  logic [GRANT_W-1:0] sel;
  logic               sel_ok;
  logic               sel_vld;
  logic [FLIT_W-1:0]  sel_flit;
  logic [1:0]         ftype;
  logic               q_full;
  logic               xfer;
  logic               pop;
  logic               bad_grant;
  logic               bad_type;

  // Source select, per-port accept and transfer qualification
  always_comb begin
    bad_grant = 1'b0;
    sel       = grant;
    sel_ok    = 1'b0;
    if (state == LOCKED) begin
      sel    = lport;
      sel_ok = 1'b1;
    end else begin
      bad_grant = grant_valid && ({1'b0, grant} >= NP);
      sel_ok    = grant_valid && ({1'b0, grant} < NP);
    end
    q_full   = (q_cnt == 2'd2);
    in_ready = '0;
    sel_vld  = 1'b0;
    sel_flit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == GRANT_W'(i)) begin
        in_ready[i] = sel_ok && !q_full;
        sel_vld     = in_valid[i];
        sel_flit    = in_flit[i*FLIT_W +: FLIT_W];
      end
    end
    xfer  = sel_ok && !q_full && sel_vld;
    ftype = sel_flit[FLIT_W-1 -: 2];
    pop   = (q_cnt != 2'd0) && out_ready;
    bad_type = (state == IDLE)
             ? (ftype == T_BODY || ftype == T_TAIL)
             : (ftype == T_HEAD || ftype == T_SNGL);
  end

  assign out_valid = (q_cnt != 2'd0);
  assign out_flit  = q0;
  assign locked    = (state == LOCKED);
  assign lock_port = lport;

  // Packet lock: HEAD opens, TAIL closes; misplaced types pass through
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      lport <= '0;
    end else if (xfer) begin
      unique case (state)
        IDLE: begin
          if (ftype == T_HEAD) begin
            state <= LOCKED;
            lport <= sel;
          end
        end
        LOCKED: begin
          if (ftype == T_TAIL) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry FIFO; unused slots kept at zero so out_flit is 0 when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0    <= '0;
      q1    <= '0;
      q_cnt <= 2'd0;
    end else begin
      unique case ({xfer, pop})
        2'b10: begin
          if (q_cnt == 2'd0) q0 <= sel_flit;
          else               q1 <= sel_flit;
          q_cnt <= q_cnt + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          q1    <= '0;
          q_cnt <= q_cnt - 2'd1;
        end
        2'b11: q0 <= sel_flit;
        default: ;
      endcase
    end
  end

  // Error pulses and accepted-flit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_err <= 1'b0;
      proto_err <= 1'b0;
      flit_cnt  <= '0;
    end else begin
      grant_err <= bad_grant;
      proto_err <= xfer && bad_type;
      if (xfer) flit_cnt <= flit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_noc_out_port_mux.sv
// Directed bench for noc_out_port_mux: vector table
// plus back-pressure and mid-packet reset sequences.
module tb_noc_out_port_mux;

  logic         clk;
  logic         rst_n;
  logic         grant_valid;
  logic [2:0]   grant;
  logic [159:0] in_flit;
  logic [4:0]   in_valid;
  logic [4:0]   in_ready;
  logic [31:0]  out_flit;
  logic         out_valid;
  logic         out_ready;
  logic         locked;
  logic [2:0]   lock_port;
  logic         grant_err;
  logic         proto_err;
  logic [15:0]  flit_cnt;

  int n_tests;
  int n_fail;

  noc_out_port_mux dut (
    .clk(clk), .rst_n(rst_n),
    .grant_valid(grant_valid), .grant(grant),
    .in_flit(in_flit), .in_valid(in_valid), .in_ready(in_ready),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .locked(locked), .lock_port(lock_port),
    .grant_err(grant_err), .proto_err(proto_err),
    .flit_cnt(flit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        gv;
    logic [2:0]  grant;
    logic [4:0]  vld;
    int          port;
    logic [31:0] flit;
    logic        ordy;
    logic [4:0]  e_rdy;
    logic        e_oval;
    logic [31:0] e_oflit;
    logic        e_lock;
    logic [2:0]  e_lport;
    logic        e_gerr;
    logic        e_perr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic gv, input logic [2:0] g,
                       input logic [4:0] vld, input int port,
                       input logic [31:0] flit, input logic ordy);
    grant_valid = gv;
    grant       = g;
    in_valid    = vld;
    out_ready   = ordy;
    for (int i = 0; i < 5; i++)
      in_flit[i*32 +: 32] = (i == port) ? flit : 32'h4000_0BAD;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(1'b0, 3'd0, 5'd0, 0, 32'h0, 1'b1);

    //           gv grant vld      port flit          ordy rdy       oval oflit         lk lp   ge  pe  cnt
    vt[0]  = '{1'b1, 3'd4, 5'b10000, 4, 32'hC000_0005, 1'b1, 5'b10000, 1'b1, 32'hC000_0005, 1'b0, 3'd0, 1'b0, 1'b0, 16'd1};
    vt[1]  = '{1'b1, 3'd1, 5'b00010, 1, 32'h0000_0011, 1'b1, 5'b00010, 1'b1, 32'h0000_0011, 1'b1, 3'd1, 1'b0, 1'b0, 16'd2};
    vt[2]  = '{1'b1, 3'd2, 5'b00110, 1, 32'h4000_0012, 1'b1, 5'b00010, 1'b1, 32'h4000_0012, 1'b1, 3'd1, 1'b0, 1'b0, 16'd3};
    vt[3]  = '{1'b1, 3'd2, 5'b00110, 1, 32'h8000_0013, 1'b1, 5'b00010, 1'b1, 32'h8000_0013, 1'b0, 3'd1, 1'b0, 1'b0, 16'd4};
    vt[4]  = '{1'b0, 3'd0, 5'b00000, 0, 32'h0000_0000, 1'b1, 5'b00000, 1'b0, 32'h0000_0000, 1'b0, 3'd1, 1'b0, 1'b0, 16'd4};
    vt[5]  = '{1'b1, 3'd6, 5'b11111, 0, 32'hC000_00FF, 1'b1, 5'b00000, 1'b0, 32'h0000_0000, 1'b0, 3'd1, 1'b1, 1'b0, 16'd4};
    vt[6]  = '{1'b0, 3'd0, 5'b00000, 0, 32'h0000_0000, 1'b1, 5'b00000, 1'b0, 32'h0000_0000, 1'b0, 3'd1, 1'b0, 1'b0, 16'd4};
    vt[7]  = '{1'b1, 3'd0, 5'b00001, 0, 32'h4000_0021, 1'b1, 5'b00001, 1'b1, 32'h4000_0021, 1'b0, 3'd1, 1'b0, 1'b1, 16'd5};
    vt[8]  = '{1'b0, 3'd0, 5'b00000, 0, 32'h0000_0000, 1'b1, 5'b00000, 1'b0, 32'h0000_0000, 1'b0, 3'd1, 1'b0, 1'b0, 16'd5};
    vt[9]  = '{1'b1, 3'd3, 5'b01000, 3, 32'h0000_0031, 1'b1, 5'b01000, 1'b1, 32'h0000_0031, 1'b1, 3'd3, 1'b0, 1'b0, 16'd6};
    vt[10] = '{1'b1, 3'd0, 5'b01001, 3, 32'hC000_0032, 1'b1, 5'b01000, 1'b1, 32'hC000_0032, 1'b1, 3'd3, 1'b0, 1'b1, 16'd7};
    vt[11] = '{1'b1, 3'd7, 5'b01000, 3, 32'h8000_0033, 1'b1, 5'b01000, 1'b1, 32'h8000_0033, 1'b0, 3'd3, 1'b0, 1'b0, 16'd8};
    vt[12] = '{1'b0, 3'd0, 5'b00000, 0, 32'h0000_0000, 1'b1, 5'b00000, 1'b0, 32'h0000_0000, 1'b0, 3'd3, 1'b0, 1'b0, 16'd8};

    // reset state
    #12;
    chk("rst_oval", {31'd0, out_valid}, 32'd0);
    chk("rst_oflit", out_flit, 32'd0);
    chk("rst_lock", {31'd0, locked}, 32'd0);
    chk("rst_cnt", {16'd0, flit_cnt}, 32'd0);
    chk("rst_errs", {30'd0, grant_err, proto_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // vector table
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      drive(vt[k].gv, vt[k].grant, vt[k].vld, vt[k].port,
            vt[k].flit, vt[k].ordy);
      #1;
      chk($sformatf("v%0d_rdy", k), {27'd0, in_ready}, {27'd0, vt[k].e_rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_oval", k), {31'd0, out_valid}, {31'd0, vt[k].e_oval});
      chk($sformatf("v%0d_oflit", k), out_flit, vt[k].e_oflit);
      chk($sformatf("v%0d_lock", k), {31'd0, locked}, {31'd0, vt[k].e_lock});
      if (vt[k].e_lock)
        chk($sformatf("v%0d_lport", k), {29'd0, lock_port}, {29'd0, vt[k].e_lport});
      chk($sformatf("v%0d_gerr", k), {31'd0, grant_err}, {31'd0, vt[k].e_gerr});
      chk($sformatf("v%0d_perr", k), {31'd0, proto_err}, {31'd0, vt[k].e_perr});
      chk($sformatf("v%0d_cnt", k), {16'd0, flit_cnt}, {16'd0, vt[k].e_cnt});
    end

    // back-pressure: queue fills at 2, drains in order
    @(negedge clk);
    drive(1'b1, 3'd2, 5'b00100, 2, 32'h0000_00A1, 1'b0);
    #1 chk("bp_rdy_a", {27'd0, in_ready}, 32'b00100);
    @(posedge clk); #1;
    chk("bp_head_a", out_flit, 32'h0000_00A1);
    @(negedge clk);
    drive(1'b1, 3'd2, 5'b00100, 2, 32'h4000_00B2, 1'b0);
    #1 chk("bp_rdy_b", {27'd0, in_ready}, 32'b00100);
    @(posedge clk); #1;
    chk("bp_hold_a", out_flit, 32'h0000_00A1);
    @(negedge clk);
    drive(1'b1, 3'd2, 5'b00100, 2, 32'h8000_00C3, 1'b0);
    #1 chk("bp_full", {27'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp_cnt_full", {16'd0, flit_cnt}, 32'd10);
    @(negedge clk);
    out_ready = 1'b1;
    #1 chk("bp_nobypass", {27'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp_pop_b", out_flit, 32'h4000_00B2);
    @(negedge clk);
    #1 chk("bp_rdy_c", {27'd0, in_ready}, 32'b00100);
    @(posedge clk); #1;
    chk("bp_pop_c", out_flit, 32'h8000_00C3);
    chk("bp_unlock", {31'd0, locked}, 32'd0);
    @(negedge clk);
    drive(1'b0, 3'd0, 5'd0, 0, 32'h0, 1'b1);
    @(posedge clk); #1;
    chk("bp_empty", {31'd0, out_valid}, 32'd0);
    chk("bp_cnt", {16'd0, flit_cnt}, 32'd11);

    // reset while locked with two flits queued
    @(negedge clk);
    drive(1'b1, 3'd0, 5'b00001, 0, 32'h0000_00D1, 1'b0);
    @(negedge clk);
    drive(1'b1, 3'd0, 5'b00001, 0, 32'h4000_00D2, 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_lock", {31'd0, locked}, 32'd1);
    chk("pre_rst_cnt", {16'd0, flit_cnt}, 32'd13);
    @(negedge clk);
    drive(1'b0, 3'd0, 5'd0, 0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_oval", {31'd0, out_valid}, 32'd0);
    chk("mr_oflit", out_flit, 32'd0);
    chk("mr_lock", {31'd0, locked}, 32'd0);
    chk("mr_lport", {29'd0, lock_port}, 32'd0);
    chk("mr_cnt", {16'd0, flit_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 3'd4, 5'b10000, 4, 32'hC000_00E1, 1'b1);
    #1 chk("post_rdy", {27'd0, in_ready}, 32'b10000);
    @(posedge clk); #1;
    chk("post_oflit", out_flit, 32'hC000_00E1);
    chk("post_cnt", {16'd0, flit_cnt}, 32'd1);
    chk("post_lock", {31'd0, locked}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
